// File: rtl/fp16_mac_accumulator.sv
// fp16_mac_accumulator: sums a programmed number of FP16 products, one term
// at a time, through an ACCUM -> ALIGN -> ADD -> NORM sequence. Rounding is
// by truncation. The final sum is held on out_data/out_valid until taken.
// Optional feature macro: FP16_ACC_OVF_FLAG_EN adds a sticky 'ovf' output
// that records any saturation during the current job.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_valid/in_data are held by the producer until accepted;
// out_valid/out_data are held by this block until out_ready is seen.
module fp16_mac_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] acc_len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy
`ifdef FP16_ACC_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [2:0] {IDLE, ACCUM, ALIGN, ADD, NORM, DONE} state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      op_q;
    logic [13:0]      sig_a, sig_b;   // aligned significands (acc, new term)
    logic             sign_a, sign_b;
    logic             inf_q;          // an operand carried exponent field 31
    logic [4:0]       exp_q;          // common exponent, then result exponent
    logic [13:0]      mant_q;         // result significand being normalised
    logic             sign_r;

    // Alignment: unpack both operands and shift the smaller-exponent one right
    logic [4:0]  ea, eb, al_exp, al_d;
    logic [13:0] ma, mb, al_a, al_b;
    always_comb begin
        ea     = (acc[14:10] == 5'd0)  ? 5'd1 : acc[14:10];
        eb     = (op_q[14:10] == 5'd0) ? 5'd1 : op_q[14:10];
        ma     = {(acc[14:10] != 5'd0), acc[9:0], 3'b000};
        mb     = {(op_q[14:10] != 5'd0), op_q[9:0], 3'b000};
        al_a   = ma;
        al_b   = mb;
        al_exp = ea;
        al_d   = 5'd0;
        if (ea >= eb) begin
            al_d   = ea - eb;
            al_exp = ea;
            al_b   = (al_d >= 5'd14) ? 14'd0 : (mb >> al_d);
        end else begin
            al_d   = eb - ea;
            al_exp = eb;
            al_a   = (al_d >= 5'd14) ? 14'd0 : (ma >> al_d);
        end
    end

    // Signed-magnitude add/subtract with carry handling and saturation
    logic [14:0] add_sum;
    logic [13:0] add_mant;
    logic [5:0]  add_exp;
    logic        add_sign, add_sat;
    always_comb begin
        add_sum  = {1'b0, sig_a} + {1'b0, sig_b};
        add_mant = 14'd0;
        add_exp  = {1'b0, exp_q};
        add_sign = sign_a;
        add_sat  = inf_q;
        if (sign_a == sign_b) begin
            if (add_sum[14]) begin
                add_mant = add_sum[14:1];
                add_exp  = {1'b0, exp_q} + 6'd1;
            end else begin
                add_mant = add_sum[13:0];
            end
        end else if (sig_a >= sig_b) begin
            add_mant = sig_a - sig_b;
            add_sign = sign_a;
        end else begin
            add_mant = sig_b - sig_a;
            add_sign = sign_b;
        end
        if (add_exp > 6'd30) add_sat = 1'b1;
        if (add_sat) begin
            // Largest finite magnitude: exp 30, all fraction bits set
            add_mant = {1'b1, 10'h3FF, 3'b000};
            add_exp  = 6'd30;
        end else if (add_mant == 14'd0) begin
            // Exact zero becomes +0; exp 1 lets NORM exit at once
            add_sign = 1'b0;
            add_exp  = 6'd1;
        end
    end

    logic        norm_done;
    logic [15:0] norm_word;
    always_comb begin
        norm_done = mant_q[13] || (exp_q <= 5'd1);
        norm_word = {sign_r, (mant_q[13] ? exp_q : 5'd0), mant_q[12:3]};
    end

    // Main control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            cnt       <= '0;
            op_q      <= 16'h0000;
            sig_a     <= 14'd0;
            sig_b     <= 14'd0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            inf_q     <= 1'b0;
            exp_q     <= 5'd0;
            mant_q    <= 14'd0;
            sign_r    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= 16'h0000;
                        busy <= 1'b1;
                        if (acc_len == '0) begin
                            out_data  <= 16'h0000;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt      <= acc_len;
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        op_q     <= in_data;
                        cnt      <= cnt - 1'b1;
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sig_a  <= al_a;
                    sig_b  <= al_b;
                    sign_a <= acc[15];
                    sign_b <= op_q[15];
                    exp_q  <= al_exp;
                    inf_q  <= (acc[14:10] == 5'd31) || (op_q[14:10] == 5'd31);
                    state  <= ADD;
                end
                ADD: begin
                    mant_q <= add_mant;
                    exp_q  <= add_exp[4:0];
                    sign_r <= add_sign;
                    state  <= NORM;
                end
                NORM: begin
                    if (!norm_done) begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - 5'd1;
                    end else begin
                        acc <= norm_word;
                        if (cnt == '0) begin
                            out_data  <= norm_word;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP16_ACC_OVF_FLAG_EN
    // Sticky saturation flag, cleared by the next honoured start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ovf <= 1'b0;
        else if (state == IDLE && start) ovf <= 1'b0;
        else if (state == ADD && add_sat) ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fp16_mac_accumulator.sv
// Directed bench for fp16_mac_accumulator. Inputs change on falling edges,
// outputs are sampled on falling edges.
module tb_fp16_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  acc_len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
`ifdef FP16_ACC_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int lat;

    fp16_mac_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_len   (acc_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef FP16_ACC_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        acc_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Offers one term; returns at the first falling edge after the handshake
    task automatic send_term(input logic [15:0] d);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts falling edges since the handshake until out_valid (bounded)
    task automatic wait_done(output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", {15'd0, out_valid}, 16'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", {15'd0, out_valid}, 16'd0);
        check("busy_drop", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_out_data", out_data, 16'h0000);
`ifdef FP16_ACC_OVF_FLAG_EN
        check("rst_ovf", {15'd0, ovf}, 16'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0 with per-term timing
        do_start(8'd2);
        check("a_busy", {15'd0, busy}, 16'd1);
        check("a_in_ready", {15'd0, in_ready}, 16'd1);
        send_term(16'h3C00);
        check("a_rdy_n1", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        check("a_rdy_n2", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        check("a_rdy_n3", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        check("a_rdy_n4", {15'd0, in_ready}, 16'd1);
        send_term(16'h4000);
        wait_done(lat);
        check("a_latency", lat[15:0], 16'd4);
        check("a_sum", out_data, 16'h4200);
        release_out();

        // Cancellation with 10 normalise shifts
        do_start(8'd2);
        send_term(16'h3C01);
        send_term(16'hBC00);
        wait_done(lat);
        check("b_latency", lat[15:0], 16'd14);
        check("b_sum", out_data, 16'h1400);
        release_out();

        // Exact cancellation gives +0
        do_start(8'd2);
        send_term(16'h3C00);
        send_term(16'hBC00);
        wait_done(lat);
        check("c_sum", out_data, 16'h0000);
        release_out();

        // Two subnormals summing to the smallest normal
        do_start(8'd2);
        send_term(16'h0200);
        send_term(16'h0200);
        wait_done(lat);
        check("d_sum", out_data, 16'h0400);
        release_out();

        // Zero-length job
        do_start(8'd0);
        check("e_valid", {15'd0, out_valid}, 16'd1);
        check("e_sum", out_data, 16'h0000);
        check("e_in_ready", {15'd0, in_ready}, 16'd0);
        release_out();

        // Saturation, then hold in DONE with an ignored start
        do_start(8'd2);
        send_term(16'h7BFF);
        send_term(16'h7BFF);
        wait_done(lat);
        check("f_sum", out_data, 16'h7BFF);
`ifdef FP16_ACC_OVF_FLAG_EN
        check("f_ovf", {15'd0, ovf}, 16'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start   = 1'b1;
                acc_len = 8'd1;
            end
            @(negedge clk);
            start = 1'b0;
            check("f_hold_data", out_data, 16'h7BFF);
            check("f_hold_valid", {15'd0, out_valid}, 16'd1);
            check("f_hold_rdy", {15'd0, in_ready}, 16'd0);
        end
`ifdef FP16_ACC_OVF_FLAG_EN
        check("f_ovf_kept", {15'd0, ovf}, 16'd1);
`endif
        release_out();
        do_start(8'd1);
`ifdef FP16_ACC_OVF_FLAG_EN
        check("f_ovf_clr", {15'd0, ovf}, 16'd0);
`endif
        send_term(16'h3C00);
        wait_done(lat);
        check("f2_sum", out_data, 16'h3C00);
        release_out();

        // Asynchronous reset during NORM of a 3-term job
        do_start(8'd3);
        send_term(16'h3C01);
        send_term(16'hBC00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("g_busy_norm", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("g_rst_busy", {15'd0, busy}, 16'd0);
        check("g_rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("g_rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("g_rst_out_data", out_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("g_idle_valid", {15'd0, out_valid}, 16'd0);
        do_start(8'd1);
        send_term(16'hC000);
        wait_done(lat);
        check("g_latency", lat[15:0], 16'd4);
        check("g_sum", out_data, 16'hC000);
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
